// File: rtl/spi_target.sv
// SPI target (mode 0, CPOL by parameter): oversamples SCK/nSS/MOSI on i_clk, receives MSB-first bytes, replies on MISO.
// Optional build macro SPI_TARGET_OVR_EN adds receive-overrun tracking on o_rx_ovr.
module spi_target #(
    parameter bit         CPOL        = 1'b0,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sck,
    input  logic       i_nss,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_miso_oe,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_load,
    output logic       o_tx_full,
    output logic       o_busy,
    output logic       o_rx_ovr
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_nss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_hist;
    logic                   r_nss_hist;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_rx_sr;
    logic [7:0]             r_tx_sr;
    logic [7:0]             r_hold;
    logic                   r_tx_full;
    logic                   r_miso;
    logic                   r_miso_oe;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;

    logic       w_sck;
    logic       w_nss;
    logic       w_mosi;
    logic       w_sample;
    logic       w_shift;
    logic       w_nss_fall;
    logic       w_nss_rise;
    logic       w_byte_done;
    logic       w_sr_load;
    logic [7:0] w_next_tx;
    logic [7:0] w_rx_next;

    assign w_sck       = r_sck_sync[SYNC_STAGES-1];
    assign w_nss       = r_nss_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sample    = (r_sck_hist == CPOL) && (w_sck != CPOL);
    assign w_shift     = (r_sck_hist != CPOL) && (w_sck == CPOL);
    assign w_nss_fall  = r_nss_hist && !w_nss;
    assign w_nss_rise  = !r_nss_hist && w_nss;
    // Deselect in the same cycle as the 8th sample edge suppresses completion.
    assign w_byte_done = (r_state == ST_SHIFT) && !w_nss_rise && w_sample && (r_bitcnt == 3'd7);
    assign w_sr_load   = ((r_state == ST_IDLE) && w_nss_fall) || w_byte_done;
    assign w_next_tx   = r_tx_full ? r_hold : IDLE_BYTE;
    assign w_rx_next   = {r_rx_sr[6:0], w_mosi};

    // Input synchronisers and edge-detect history
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sck_sync  <= {SYNC_STAGES{CPOL}};
            r_nss_sync  <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= {SYNC_STAGES{1'b0}};
            r_sck_hist  <= CPOL;
            r_nss_hist  <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], i_nss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sck_hist  <= w_sck;
            r_nss_hist  <= w_nss;
        end
    end

    // Transfer FSM, shift registers and reply holding register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= 3'd0;
            r_rx_sr    <= 8'h00;
            r_tx_sr    <= 8'h00;
            r_hold     <= 8'h00;
            r_tx_full  <= 1'b0;
            r_miso     <= 1'b1;
            r_miso_oe  <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_nss_fall) begin
                        r_state   <= ST_SHIFT;
                        r_bitcnt  <= 3'd0;
                        r_tx_sr   <= w_next_tx;
                        r_miso    <= w_next_tx[7];
                        r_miso_oe <= 1'b1;
                    end else begin
                        r_miso    <= 1'b1;
                        r_miso_oe <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_nss_rise) begin
                        r_state   <= ST_IDLE;
                        r_bitcnt  <= 3'd0;
                        r_miso    <= 1'b1;
                        r_miso_oe <= 1'b0;
                    end else if (w_sample) begin
                        r_rx_sr  <= w_rx_next;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            r_tx_sr    <= w_next_tx;
                        end else begin
                            r_rx_data <= r_rx_data;
                        end
                    end else if (w_shift) begin
                        // bitcnt==0 here only right after a byte: present the freshly loaded MSB.
                        if (r_bitcnt != 3'd0) begin
                            r_miso  <= r_tx_sr[6];
                            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                        end else begin
                            r_miso <= r_tx_sr[7];
                        end
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (i_tx_load) begin
                r_hold    <= i_tx_data;
                r_tx_full <= 1'b1;
            end else if (w_sr_load) begin
                r_tx_full <= 1'b0;
            end else begin
                r_tx_full <= r_tx_full;
            end
        end
    end

    assign o_miso     = r_miso;
    assign o_miso_oe  = r_miso_oe;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_tx_full  = r_tx_full;
    assign o_busy     = (r_state == ST_SHIFT) && (r_bitcnt != 3'd0);

`ifdef SPI_TARGET_OVR_EN
    logic r_unack;
    logic r_rx_ovr;

    // Overrun tracking: a TX_LOAD acknowledges the last received byte
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_unack  <= 1'b0;
            r_rx_ovr <= 1'b0;
        end else begin
            if (w_byte_done) begin
                r_unack <= 1'b1;
            end else if (i_tx_load) begin
                r_unack <= 1'b0;
            end else begin
                r_unack <= r_unack;
            end
            if (w_byte_done && r_unack) begin
                r_rx_ovr <= 1'b1;
            end else if (i_tx_load) begin
                r_rx_ovr <= 1'b0;
            end else begin
                r_rx_ovr <= r_rx_ovr;
            end
        end
    end

    assign o_rx_ovr = r_rx_ovr;
`else
    assign o_rx_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a CPOL=0 and a CPOL=1 instance driven by a slow bit-banged master.
module tb_spi_target;
`ifdef SPI_TARGET_OVR_EN
    localparam bit OVR_ON = 1'b1;
`else
    localparam bit OVR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck_ph = 1'b0;
    logic       nss0 = 1'b1;
    logic       nss1 = 1'b1;
    logic       mosi = 1'b0;
    logic       tx_load0 = 1'b0;
    logic       tx_load1 = 1'b0;
    logic [7:0] tx_data = 8'h00;
    bit         sel = 1'b0;

    logic       miso0, oe0, rxv0, full0, busy0, ovr0;
    logic       miso1, oe1, rxv1, full1, busy1, ovr1;
    logic [7:0] rxd0, rxd1;
    logic [7:0] mi;

    int n_checks = 0;
    int n_pass   = 0;
    int rxcnt0   = 0;
    int rxcnt1   = 0;
    int bad1     = 0;
    logic prev_miso1 = 1'b1;

    always #5 clk = ~clk;

    spi_target #(.CPOL(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_sck(sck_ph), .i_nss(nss0), .i_mosi(mosi),
        .o_miso(miso0), .o_miso_oe(oe0), .o_rx_data(rxd0), .o_rx_valid(rxv0),
        .i_tx_data(tx_data), .i_tx_load(tx_load0), .o_tx_full(full0),
        .o_busy(busy0), .o_rx_ovr(ovr0)
    );

    spi_target #(.CPOL(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_sck(~sck_ph), .i_nss(nss1), .i_mosi(mosi),
        .o_miso(miso1), .o_miso_oe(oe1), .o_rx_data(rxd1), .o_rx_valid(rxv1),
        .i_tx_data(tx_data), .i_tx_load(tx_load1), .o_tx_full(full1),
        .o_busy(busy1), .o_rx_ovr(ovr1)
    );

    // Strobe counters and a watch on MISO of the CPOL=1 instance during sample phases
    always @(negedge clk) begin
        if (rxv0 === 1'b1) rxcnt0 <= rxcnt0 + 1;
        if (rxv1 === 1'b1) rxcnt1 <= rxcnt1 + 1;
        if ((miso1 !== prev_miso1) && (sck_ph === 1'b1)) bad1 <= bad1 + 1;
        prev_miso1 <= miso1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_bits(input int n);
        for (int i = 0; i < n; i++) begin
            mosi = 1'b1;
            wait_clks(4);
            sck_ph = 1'b1;
            wait_clks(8);
            sck_ph = 1'b0;
            wait_clks(4);
        end
    endtask

    // One byte: MOSI set after the shift edge, MISO read just before the sample edge.
    task automatic xfer(input logic [7:0] mo, input bit load_last, input logic [7:0] ld, output logic [7:0] got);
        for (int i = 7; i >= 0; i--) begin
            mosi = mo[i];
            wait_clks(4);
            got[i] = sel ? miso1 : miso0;
            sck_ph = 1'b1;
            if (load_last && (i == 0)) begin
                wait_clks(2);
                tx_data  = ld;
                tx_load0 = 1'b1;
                wait_clks(1);
                tx_load0 = 1'b0;
                wait_clks(5);
            end else begin
                wait_clks(8);
            end
            sck_ph = 1'b0;
            wait_clks(4);
        end
    endtask

    task automatic load0(input logic [7:0] d);
        tx_data  = d;
        tx_load0 = 1'b1;
        wait_clks(1);
        tx_load0 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clks(4);
        rst = 1'b0;
        wait_clks(2);
        check("rst_miso",  32'(miso0), 32'd1);
        check("rst_oe",    32'(oe0),   32'd0);
        check("rst_rxd",   32'(rxd0),  32'd0);
        check("rst_rxv",   32'(rxv0),  32'd0);
        check("rst_full",  32'(full0), 32'd0);
        check("rst_busy",  32'(busy0), 32'd0);
        check("rst_ovr",   32'(ovr0),  32'd0);
        check("rst_miso1", 32'(miso1), 32'd1);

        // Plain byte with nothing queued: idle reply
        nss0 = 1'b0;
        wait_clks(6);
        check("sel_oe", 32'(oe0), 32'd1);
        xfer(8'hA5, 1'b0, 8'h00, mi);
        check("a5_miso",  32'(mi),     32'hFF);
        check("a5_cnt",   32'(rxcnt0), 32'd1);
        check("a5_rxd",   32'(rxd0),   32'hA5);
        check("a5_busy",  32'(busy0),  32'd0);
        nss0 = 1'b1;
        wait_clks(6);
        check("desel_oe",   32'(oe0),   32'd0);
        check("desel_miso", 32'(miso0), 32'd1);

        // Queued reply then idle byte
        load0(8'h3C);
        check("3c_full_set", 32'(full0), 32'd1);
        nss0 = 1'b0;
        wait_clks(6);
        check("3c_full_clr", 32'(full0), 32'd0);
        xfer(8'h00, 1'b0, 8'h00, mi);
        check("3c_miso", 32'(mi), 32'h3C);
        xfer(8'h00, 1'b0, 8'h00, mi);
        check("3c_idle", 32'(mi), 32'hFF);
        check("3c_cnt",  32'(rxcnt0), 32'd3);
        nss0 = 1'b1;
        wait_clks(6);

        // Partial byte discarded on deselect
        nss0 = 1'b0;
        wait_clks(6);
        pulse_bits(5);
        check("part_busy", 32'(busy0), 32'd1);
        nss0 = 1'b1;
        wait_clks(6);
        check("part_busy_clr", 32'(busy0),  32'd0);
        check("part_cnt",      32'(rxcnt0), 32'd3);
        nss0 = 1'b0;
        wait_clks(6);
        xfer(8'h81, 1'b0, 8'h00, mi);
        check("81_rxd", 32'(rxd0),   32'h81);
        check("81_cnt", 32'(rxcnt0), 32'd4);
        nss0 = 1'b1;
        wait_clks(6);

        // CPOL=1 instance
        tx_data  = 8'h96;
        tx_load1 = 1'b1;
        wait_clks(1);
        tx_load1 = 1'b0;
        sel  = 1'b1;
        nss1 = 1'b0;
        wait_clks(6);
        xfer(8'h5A, 1'b0, 8'h00, mi);
        check("cpol1_miso", 32'(mi),     32'h96);
        check("cpol1_rxd",  32'(rxd1),   32'h5A);
        check("cpol1_cnt",  32'(rxcnt1), 32'd1);
        check("cpol1_edge", 32'(bad1),   32'd0);
        nss1 = 1'b1;
        wait_clks(6);
        sel = 1'b0;

        // TX_LOAD on the completion cycle: shifter takes the idle byte
        nss0 = 1'b0;
        wait_clks(6);
        xfer(8'h00, 1'b1, 8'h11, mi);
        check("race_b0",   32'(mi),    32'hFF);
        check("race_full", 32'(full0), 32'd1);
        xfer(8'h00, 1'b0, 8'h00, mi);
        check("race_b1",    32'(mi),    32'hFF);
        check("race_full2", 32'(full0), 32'd0);
        xfer(8'h00, 1'b0, 8'h00, mi);
        check("race_b2",  32'(mi),     32'h11);
        check("race_cnt", 32'(rxcnt0), 32'd7);
        nss0 = 1'b1;
        wait_clks(6);

        // Overrun: two unacknowledged bytes
        load0(8'h00);
        check("ovr_init", 32'(ovr0), 32'd0);
        nss0 = 1'b0;
        wait_clks(6);
        xfer(8'h12, 1'b0, 8'h00, mi);
        check("ovr_b1", 32'(ovr0), 32'd0);
        xfer(8'h34, 1'b0, 8'h00, mi);
        check("ovr_b2", 32'(ovr0), 32'(OVR_ON));
        load0(8'h55);
        check("ovr_clr", 32'(ovr0), 32'd0);
        nss0 = 1'b1;
        wait_clks(6);

        // Reset in the middle of a byte
        check("pre_rst_full", 32'(full0), 32'd1);
        nss0 = 1'b0;
        wait_clks(6);
        pulse_bits(3);
        check("mid_busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        check("mid_rst_oe",   32'(oe0),   32'd0);
        check("mid_rst_miso", 32'(miso0), 32'd1);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_full", 32'(full0), 32'd0);
        check("mid_rst_ovr",  32'(ovr0),  32'd0);
        nss0 = 1'b1;
        wait_clks(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
